// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one row low per slot, frame debounce, key events and player movement.
// Latency: a press commits one clk after the frame end that brings its stable count to DEBOUNCE_FRAMES.
// Backpressure: none; free-running scan, events are single-cycle pulses with no ready.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 50,
    parameter int UP_CODE         = 1,
    parameter int DOWN_CODE       = 9,
    parameter int FIRE_CODE       = 5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] keypadRow,
    input  logic [3:0] keypadCol,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [2:0] playerPos,
    output logic       fire
);

    localparam int              SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam int              RW        = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0]   REP_LAST  = RW'(REPEAT_FRAMES - 1);
    localparam logic [3:0]      DEB_CNT   = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0]      UP_K      = 4'(UP_CODE);
    localparam logic [3:0]      DN_K      = 4'(DOWN_CODE);
    localparam logic [3:0]      FIRE_K    = 4'(FIRE_CODE);
    localparam logic [2:0]      POS_MIN   = 3'd1;
    localparam logic [2:0]      POS_MAX   = 3'd6;
    localparam logic [2:0]      POS_RST   = 3'd3;

    // Column synchronizer
    logic [3:0] col_s1_q, col_s2_q;

    // Scan state
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_q, row_d;
    logic [15:0]   frame_q, frame_d;

    // Debounce state; candidate is {is_code, code}, 5'd0 meaning NONE
    logic [4:0] cand_q, cand_d;
    logic [3:0] stab_q, stab_d;
    logic       commit_q, commit_d;
    logic [4:0] commit_cls_q, commit_cls_d;
    logic       frame_end_q;

    // Committed key and movement state
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [2:0]    pos_q, pos_d;
    logic          fire_q, fire_d;
    logic [RW-1:0] rep_q, rep_d;

    logic       slot_last, frame_end;
    logic [3:0] col_act;
    logic [4:0] n_set;
    logic [3:0] hit_idx;
    logic       cls_multi;
    logic [4:0] cls;
    logic       press_evt, release_evt, move_key, move_up, move_dn;

    assign slot_last = (slot_q == SLOT_LAST);
    assign frame_end = slot_last && (row_idx_q == 2'd3);
    assign col_act   = ~col_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= keypadCol;
            col_s2_q <= col_s1_q;
        end
    end

    always_comb begin
        slot_d    = slot_last ? '0 : slot_q + 1'b1;
        row_idx_d = row_idx_q;
        row_d     = row_q;
        frame_d   = frame_q;
        if (slot_last) begin
            frame_d[{row_idx_q, 2'b00} +: 4] = col_act;
            row_idx_d = row_idx_q + 2'd1;
            row_d     = {row_q[2:0], row_q[3]};
        end
    end

    // frame_d already holds the row-3 nibble on the frame-end edge
    always_comb begin
        n_set   = 5'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_d[i]) begin
                n_set   = n_set + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign cls_multi = (n_set > 5'd1);
    assign cls       = (n_set == 5'd1) ? {1'b1, hit_idx} : 5'd0;

    always_comb begin
        cand_d       = cand_q;
        stab_d       = stab_q;
        commit_d     = 1'b0;
        commit_cls_d = commit_cls_q;
        if (frame_end) begin
            if (cls_multi) begin
                cand_d = 5'd0;
                stab_d = 4'd0;
            end else begin
                if (cls == cand_q) begin
                    stab_d = (stab_q == 4'd15) ? 4'd15 : stab_q + 4'd1;
                end else begin
                    cand_d = cls;
                    stab_d = 4'd1;
                end
                // Saturation at 15 must not re-fire when DEBOUNCE_FRAMES is 15
                commit_d     = (stab_d == DEB_CNT) && ((stab_q != DEB_CNT) || (cls != cand_q));
                commit_cls_d = cls;
            end
        end
    end

    assign press_evt   = commit_q && commit_cls_q[4] &&
                         (!key_held_q || (commit_cls_q[3:0] != key_code_q));
    assign release_evt = commit_q && !commit_cls_q[4];
    assign move_key    = (key_code_q == UP_K) || (key_code_q == DN_K);

    always_comb begin
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        rep_d       = rep_q;
        pos_d       = pos_q;
        move_up     = 1'b0;
        move_dn     = 1'b0;
        if (press_evt) begin
            key_code_d  = commit_cls_q[3:0];
            key_held_d  = 1'b1;
            key_valid_d = 1'b1;
            rep_d       = '0;
            move_up     = (commit_cls_q[3:0] == UP_K);
            move_dn     = (commit_cls_q[3:0] == DN_K);
        end else if (release_evt) begin
            key_held_d = 1'b0;
            rep_d      = '0;
        end else if (frame_end_q && key_held_q && move_key) begin
            if (rep_q == REP_LAST) begin
                rep_d   = '0;
                move_up = (key_code_q == UP_K);
                move_dn = (key_code_q == DN_K);
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
        if (move_up && (pos_q != POS_MIN)) begin
            pos_d = pos_q - 3'd1;
        end else if (move_dn && (pos_q != POS_MAX)) begin
            pos_d = pos_q + 3'd1;
        end
        fire_d = key_held_d && (key_code_d == FIRE_K);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q       <= '0;
            row_idx_q    <= 2'd0;
            row_q        <= 4'b1110;
            frame_q      <= 16'h0000;
            cand_q       <= 5'd0;
            stab_q       <= 4'd0;
            commit_q     <= 1'b0;
            commit_cls_q <= 5'd0;
            frame_end_q  <= 1'b0;
            key_code_q   <= 4'd0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
            pos_q        <= POS_RST;
            fire_q       <= 1'b0;
            rep_q        <= '0;
        end else begin
            slot_q       <= slot_d;
            row_idx_q    <= row_idx_d;
            row_q        <= row_d;
            frame_q      <= frame_d;
            cand_q       <= cand_d;
            stab_q       <= stab_d;
            commit_q     <= commit_d;
            commit_cls_q <= commit_cls_d;
            frame_end_q  <= frame_end;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
            pos_q        <= pos_d;
            fire_q       <= fire_d;
            rep_q        <= rep_d;
        end
    end

    assign keypadRow = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign playerPos = pos_q;
    assign fire      = fire_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_FRAMES=2, REPEAT_FRAMES=3 (16-cycle frames).
// A behavioural keypad pulls columns low for whichever keys in `pressed` sit on the driven row.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  keypadRow, keypadCol, key_code;
    logic        key_valid, key_held, fire;
    logic [2:0]  playerPos;
    logic [15:0] pressed = 16'h0000;

    int cyc = 0;
    int pulses = 0;
    int total = 0;
    int bad = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(3),
        .UP_CODE(1), .DOWN_CODE(9), .FIRE_CODE(5)
    ) dut (
        .clk(clk), .rst(rst), .keypadRow(keypadRow), .keypadCol(keypadCol),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .playerPos(playerPos), .fire(fire)
    );

    always #5 clk = ~clk;

    always_comb begin
        keypadCol = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (keypadRow[r] == 1'b0) keypadCol = keypadCol & ~pressed[4*r +: 4];
        end
    end

    // cyc = number of clk edges since reset release; pulses = key_valid cycles seen
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (key_valid === 1'b1) pulses <= pulses + 1;
        end
    end

    task automatic wait_to(input int target);
        int guard = 0;
        while (cyc != target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (cyc != target) begin
            $display("FAIL wait_to: cyc=%0d required=%0d", cyc, target);
            bad++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        total++; if (keypadRow !== 4'b1110) begin $display("FAIL rst_row: got=%b exp=1110", keypadRow); bad++; end
        total++; if (key_code !== 4'd0) begin $display("FAIL rst_code: got=%0d exp=0", key_code); bad++; end
        total++; if (key_valid !== 1'b0 || key_held !== 1'b0 || fire !== 1'b0) begin
            $display("FAIL rst_flags: valid=%b held=%b fire=%b exp=000", key_valid, key_held, fire); bad++; end
        total++; if (playerPos !== 3'd3) begin $display("FAIL rst_pos: got=%0d exp=3", playerPos); bad++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_to(3);
        total++; if (keypadRow !== 4'b1110) begin $display("FAIL row0_hold: got=%b exp=1110", keypadRow); bad++; end
        wait_to(4);
        total++; if (keypadRow !== 4'b1101) begin $display("FAIL row1: got=%b exp=1101", keypadRow); bad++; end
        wait_to(7);
        total++; if (keypadRow !== 4'b1101) begin $display("FAIL row1_hold: got=%b exp=1101", keypadRow); bad++; end
        wait_to(8);
        total++; if (keypadRow !== 4'b1011) begin $display("FAIL row2: got=%b exp=1011", keypadRow); bad++; end
        wait_to(12);
        total++; if (keypadRow !== 4'b0111) begin $display("FAIL row3: got=%b exp=0111", keypadRow); bad++; end
        wait_to(16);
        total++; if (keypadRow !== 4'b1110) begin $display("FAIL row_wrap: got=%b exp=1110", keypadRow); bad++; end
        wait_to(160);
        total++; if (pulses !== 0) begin $display("FAIL idle_pulses: got=%0d exp=0", pulses); bad++; end
        total++; if (playerPos !== 3'd3 || key_held !== 1'b0) begin
            $display("FAIL idle_state: pos=%0d held=%b exp pos=3 held=0", playerPos, key_held); bad++; end
    endtask

    task automatic test_fire();
        int b = 160;
        int p0 = pulses;
        pressed = 16'h0020;
        wait_to(b + 32);
        total++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            $display("FAIL fire_early: valid=%b held=%b exp 0 0", key_valid, key_held); bad++; end
        wait_to(b + 33);
        total++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin
            $display("FAIL fire_commit: valid=%b code=%0d exp 1 5", key_valid, key_code); bad++; end
        total++; if (fire !== 1'b1 || key_held !== 1'b1) begin
            $display("FAIL fire_level: fire=%b held=%b exp 1 1", fire, key_held); bad++; end
        wait_to(b + 34);
        total++; if (key_valid !== 1'b0) begin $display("FAIL fire_pulse_width: valid=%b exp=0", key_valid); bad++; end
        wait_to(b + 48);
        pressed = 16'h0000;
        wait_to(b + 80);
        total++; if (key_held !== 1'b1) begin $display("FAIL fire_release_early: held=%b exp=1", key_held); bad++; end
        wait_to(b + 81);
        total++; if (key_held !== 1'b0 || fire !== 1'b0 || key_code !== 4'd5) begin
            $display("FAIL fire_release: held=%b fire=%b code=%0d exp 0 0 5", key_held, fire, key_code); bad++; end
        total++; if (pulses - p0 !== 1) begin $display("FAIL fire_pulse_count: got=%0d exp=1", pulses - p0); bad++; end
        wait_to(b + 96);
    endtask

    task automatic test_up_taps();
        int t = 256;
        int exp_pos[3] = '{2, 1, 1};
        int prev_pos[3] = '{3, 2, 1};
        for (int i = 0; i < 3; i++) begin
            int base = t + 96 * i;
            wait_to(base);
            pressed = 16'h0002;
            wait_to(base + 32);
            total++; if (playerPos !== 3'(prev_pos[i])) begin
                $display("FAIL up_before_%0d: pos=%0d exp=%0d", i, playerPos, prev_pos[i]); bad++; end
            wait_to(base + 33);
            total++; if (key_valid !== 1'b1 || playerPos !== 3'(exp_pos[i])) begin
                $display("FAIL up_tap_%0d: valid=%b pos=%0d exp 1 %0d", i, key_valid, playerPos, exp_pos[i]); bad++; end
            wait_to(base + 48);
            pressed = 16'h0000;
            wait_to(base + 81);
            total++; if (key_held !== 1'b0 || playerPos !== 3'(exp_pos[i])) begin
                $display("FAIL up_release_%0d: held=%b pos=%0d exp 0 %0d", i, key_held, playerPos, exp_pos[i]); bad++; end
        end
        wait_to(t + 288);
    endtask

    task automatic test_hold_down();
        int p0;
        pressed = 16'h0000;
        do_reset();
        p0 = pulses;
        pressed = 16'h0200;
        wait_to(33);
        total++; if (key_valid !== 1'b1 || key_code !== 4'd9 || playerPos !== 3'd4) begin
            $display("FAIL down_commit: valid=%b code=%0d pos=%0d exp 1 9 4", key_valid, key_code, playerPos); bad++; end
        wait_to(80);
        total++; if (playerPos !== 3'd4) begin $display("FAIL down_pre_rep1: pos=%0d exp=4", playerPos); bad++; end
        wait_to(81);
        total++; if (playerPos !== 3'd5) begin $display("FAIL down_rep1: pos=%0d exp=5", playerPos); bad++; end
        wait_to(128);
        total++; if (playerPos !== 3'd5) begin $display("FAIL down_pre_rep2: pos=%0d exp=5", playerPos); bad++; end
        wait_to(129);
        total++; if (playerPos !== 3'd6) begin $display("FAIL down_rep2: pos=%0d exp=6", playerPos); bad++; end
        wait_to(177);
        total++; if (playerPos !== 3'd6 || key_held !== 1'b1) begin
            $display("FAIL down_sat: pos=%0d held=%b exp 6 1", playerPos, key_held); bad++; end
        wait_to(192);
        pressed = 16'h0000;
        total++; if (pulses - p0 !== 1) begin $display("FAIL down_pulse_count: got=%0d exp=1", pulses - p0); bad++; end
        wait_to(225);
        total++; if (key_held !== 1'b0) begin $display("FAIL down_release: held=%b exp=0", key_held); bad++; end
        wait_to(240);
    endtask

    task automatic test_ghost();
        int g = 240;
        int p0, p1;
        pressed = 16'h0020;
        wait_to(g + 33);
        total++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin
            $display("FAIL ghost_setup: valid=%b code=%0d exp 1 5", key_valid, key_code); bad++; end
        p0 = pulses;
        wait_to(g + 48);
        pressed = 16'h0060;
        wait_to(g + 128);
        total++; if (key_code !== 4'd5 || key_held !== 1'b1 || fire !== 1'b1 || pulses !== p0) begin
            $display("FAIL ghost_reject: code=%0d held=%b fire=%b pulses=%0d exp 5 1 1 %0d",
                     key_code, key_held, fire, pulses, p0); bad++; end
        pressed = 16'h0020;
        wait_to(g + 161);
        total++; if (pulses !== p0 || key_code !== 4'd5 || key_held !== 1'b1) begin
            $display("FAIL ghost_same_key: pulses=%0d code=%0d held=%b exp %0d 5 1", pulses, key_code, key_held, p0); bad++; end
        wait_to(g + 176);
        pressed = 16'h0000;
        wait_to(g + 209);
        total++; if (key_held !== 1'b0 || fire !== 1'b0) begin
            $display("FAIL ghost_release: held=%b fire=%b exp 0 0", key_held, fire); bad++; end
        wait_to(g + 224);
        p1 = pulses;
        for (int f = 0; f < 8; f++) begin
            wait_to(g + 224 + 16 * f);
            pressed = (f % 2 == 0) ? 16'h0040 : 16'h0000;
        end
        wait_to(g + 352);
        pressed = 16'h0000;
        wait_to(g + 360);
        total++; if (pulses !== p1 || key_held !== 1'b0 || key_code !== 4'd5) begin
            $display("FAIL bounce: pulses=%0d held=%b code=%0d exp %0d 0 5", pulses, key_held, key_code, p1); bad++; end
    endtask

    task automatic test_reset_mid();
        int p0;
        pressed = 16'h0200;
        do_reset();
        wait_to(33);
        total++; if (key_valid !== 1'b1 || playerPos !== 3'd4) begin
            $display("FAIL rmid_setup: valid=%b pos=%0d exp 1 4", key_valid, playerPos); bad++; end
        wait_to(58);
        total++; if (keypadRow !== 4'b1011) begin $display("FAIL rmid_row2: row=%b exp=1011", keypadRow); bad++; end
        rst = 1'b0;
        #1;
        total++; if (keypadRow !== 4'b1110 || playerPos !== 3'd3) begin
            $display("FAIL rmid_async: row=%b pos=%0d exp 1110 3", keypadRow, playerPos); bad++; end
        total++; if (key_held !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0 || fire !== 1'b0) begin
            $display("FAIL rmid_outs: held=%b code=%0d valid=%b fire=%b exp 0 0 0 0", key_held, key_code, key_valid, fire); bad++; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p0 = pulses;
        wait_to(32);
        total++; if (playerPos !== 3'd3 || key_held !== 1'b0 || pulses !== p0) begin
            $display("FAIL rmid_early: pos=%0d held=%b pulses=%0d exp 3 0 %0d", playerPos, key_held, pulses, p0); bad++; end
        wait_to(33);
        total++; if (key_valid !== 1'b1 || playerPos !== 3'd4 || key_code !== 4'd9) begin
            $display("FAIL rmid_recommit: valid=%b pos=%0d code=%0d exp 1 4 9", key_valid, playerPos, key_code); bad++; end
    endtask

    task automatic test_back_to_back();
        int p0;
        wait_to(48);
        p0 = pulses;
        pressed = 16'h0020;
        wait_to(80);
        total++; if (key_code !== 4'd9 || key_held !== 1'b1) begin
            $display("FAIL b2b_before: code=%0d held=%b exp 9 1", key_code, key_held); bad++; end
        wait_to(81);
        total++; if (key_valid !== 1'b1 || key_code !== 4'd5 || fire !== 1'b1 || key_held !== 1'b1) begin
            $display("FAIL b2b_commit: valid=%b code=%0d fire=%b held=%b exp 1 5 1 1", key_valid, key_code, fire, key_held); bad++; end
        total++; if (playerPos !== 3'd4 || pulses - p0 !== 1) begin
            $display("FAIL b2b_pos: pos=%0d pulses=%0d exp 4 1", playerPos, pulses - p0); bad++; end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_up_taps();
        test_hold_down();
        test_ghost();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Reads the 4x4 keypad that sits beside the dot-matrix display. It is the input-side counterpart of the row-scanned matrix driver.
- Drives one keypad row low at a time and samples the active-low columns.
- Debounces whole scan frames and emits key events.
- Converts up, down and fire keys into the player position and fire level used by the game core.

Parameters:
- SCAN_DIV, 1000: clk cycles per row slot; must be >= 4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames required to commit a key state; range 1..15.
- REPEAT_FRAMES, 50: frames between auto-repeat moves while up or down is held; must be >= 1.
- UP_CODE, 1: key code that moves the player up (position decrements).
- DOWN_CODE, 9: key code that moves the player down (position increments).
- FIRE_CODE, 5: key code that fires.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- keypadRow  out  4  row drive, active-low one-hot.
- keypadCol  in  4  column sense, active-low; asynchronous to clk.
- key_code  out  4  last committed key, code = row*4 + col.
- key_valid  out  1  one-cycle pulse when a new key press commits.
- key_held  out  1  high while a committed key is down.
- playerPos  out  3  player centre row, range 1..6.
- fire  out  1  high while FIRE_CODE is committed and held.

Behaviour:
- Reset (async, rst=0):
  - keypadRow=4'b1110; row index 0; slot counter 0.
  - key_code=0, key_valid=0, key_held=0, playerPos=3, fire=0.
  - Synchronizer flops, frame word and debounce state cleared; candidate=NONE.
  - Reset asserted mid-frame discards the partial frame. Scanning restarts at row 0 on the first clk after release.
- Input sync: keypadCol passes through 2 flops. Only the synchronized value is used.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1; row r is driven for the whole slot.
  - On counter = SCAN_DIV-1: store the inverted synchronized columns into frame bits [4r+3:4r], then advance to row (r+1) mod 4 and update keypadRow on the same edge.
  - The sample point is at least 3 cycles after the row change, covering settle time plus the synchronizer.
- Frame end (the row-3 sample edge): classify the 16-bit frame word.
  - All zero: NONE.
  - Exactly one bit set: CODE = that bit index.
  - More than one bit set: INVALID. The candidate and count are cleared and committed state is unchanged (ghosting rejection).
- Debounce:
  - If the class equals the candidate, the stable count increments, saturating at 15.
  - Otherwise the candidate becomes the class and the count is set to 1.
  - A commit fires exactly on the frame where the count first reaches DEBOUNCE_FRAMES; the decision is registered one cycle after frame end.
- Commit CODE k, when k differs from the committed key or no key is held:
  - key_code=k and key_held=1.
  - key_valid pulses high for exactly 1 cycle.
  - The repeat counter is cleared.
  - A change from one held key directly to another held key is a new press (new pulse, no release between).
- Commit NONE: key_held=0; key_code keeps its last value; no pulse.
- Movement:
  - On a press commit of UP_CODE, playerPos decrements, saturating at 1.
  - On a press commit of DOWN_CODE, playerPos increments, saturating at 6.
  - While UP or DOWN stays held, the repeat counter counts frames. Each time it reaches REPEAT_FRAMES it applies one more move and resets to 0.
- fire = key_held AND key_code==FIRE_CODE, registered.
- All outputs are registered; there are no combinational paths from keypadCol.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, REPEAT_FRAMES=3; 1 frame = 16 cycles):
- Reset, then release with no keys pressed:
  - keypadRow cycles 1110→1101→1011→0111, each held for 4 clk.
  - playerPos=3; key_valid never pulses over 10 frames.
- Hold row 1 / col 1 low (code 5) for 3 frames:
  - After 2 full frames plus 1 cycle: one key_valid pulse, key_code=5, fire=1, key_held=1.
  - Release: after 2 frames fire=0, key_held=0, key_code stays 5.
- Tap UP (code 1) twice, each press and release lasting 3 frames:
  - playerPos goes 3→2→1.
  - A third tap leaves playerPos=1 (saturation) while key_valid still pulses.
- Hold DOWN (code 9) continuously for 12 frames:
  - Commit at frame 2 gives playerPos 4.
  - Repeats at frames 5 and 8 give 5 and 6; at frame 11 it stays 6.
- Press codes 5 and 6 together for 5 frames:
  - No key_valid pulse; committed state unchanged.
  - A column bounce that alternates each frame also never commits.
- Assert rst mid-row-2 while DOWN is held:
  - All outputs immediately reach reset values (playerPos=3, keypadRow=1110).
  - After release with DOWN still held: fresh commit after 2 frames, playerPos=4.
